// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline hazard sources and pipe_ctrl.
// The master drives hazard requests, and the slave (the controller) returns the stall and flush controls.
interface pipe_ctrl_if #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 16
);
  logic                id_stall_req;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                ex_mc_abort;
  logic                flush_req;
  logic                perf_clr;
  logic [5:0]          stall;
  logic                flush;
  logic                mc_busy;
  logic                mc_done;
  logic [PERF_W-1:0]   stall_cnt;

  modport master (
    output id_stall_req, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req, perf_clr,
    input  stall, flush, mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  id_stall_req, ex_mc_start, ex_mc_cycles, ex_mc_abort, flush_req, perf_clr,
    output stall, flush, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush arbiter with a multi-cycle EX sequencer
// and a saturating stall-cycle performance counter.
module pipe_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MC_RUN = 1'b1;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  logic [0:0]          fsm;
  logic [MC_CNT_W-1:0] cnt;
  logic                mc_done;
  logic [PERF_W-1:0]   stall_cnt;

  logic                running;
  logic                start_ok;
  logic                abort_ok;
  logic [5:0]          stall_c;
  logic                flush_c;

  assign running  = (fsm == MC_RUN);
  assign start_ok = !running && bus.ex_mc_start && (bus.ex_mc_cycles != '0);
  assign abort_ok = running && bus.ex_mc_abort;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  // Gating on rst drops the combinational outputs in the same cycle that the reset is asserted.
  always_comb begin
    stall_c = S_NONE;
    flush_c = 1'b0;
    if (!rst) begin
      stall_c = S_NONE;
    end else if (bus.flush_req) begin
      flush_c = 1'b1;
    end else if (abort_ok) begin
      stall_c = S_NONE;
    end else if (running || start_ok) begin
      stall_c = S_EX;
    end else if (bus.id_stall_req) begin
      stall_c = S_ID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm     <= IDLE;
      cnt     <= '0;
      mc_done <= 1'b0;
    end else begin
      mc_done <= 1'b0;
      if (bus.flush_req) begin
        fsm <= IDLE;
        cnt <= '0;
      end else if (running) begin
        if (bus.ex_mc_abort) begin
          fsm <= IDLE;
          cnt <= '0;
        end else if (cnt == MC_CNT_W'(1)) begin
          fsm     <= IDLE;
          cnt     <= '0;
          mc_done <= 1'b1;
        end else begin
          cnt <= cnt - MC_CNT_W'(1);
        end
      end else if (start_ok) begin
        // A single-cycle op finishes without entering MC_RUN.
        if (bus.ex_mc_cycles == MC_CNT_W'(1)) begin
          mc_done <= 1'b1;
        end else begin
          fsm <= MC_RUN;
          cnt <= bus.ex_mc_cycles - MC_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (bus.perf_clr) begin
      stall_cnt <= '0;
    end else if (stall_c[0] && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.flush     = flush_c;
  assign bus.mc_busy   = running;
  assign bus.mc_done   = mc_done;
  assign bus.stall_cnt = stall_cnt;

endmodule
